// File: rtl/snn_pkg.sv
// Shared state encoding and default sizing for the inference sequencer.
package snn_pkg;

   localparam int DEF_STEP_WIDTH   = 8;
   localparam int DEF_OUTPUT_WIDTH = 4;
   localparam int DEF_CLEAR_CYCLES = 2;
   localparam int DEF_TIMEOUT      = 15;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } seq_state_t;

   // An inference is in flight while the network is being cleared, fed or awaited.
   function automatic logic is_busy(input seq_state_t s);
      return (s == S_CLEAR) || (s == S_RUN) || (s == S_WAIT);
   endfunction

endpackage

// File: rtl/inference_sequencer.sv
// Sequences one spiking-network inference: clear the network, stream the
// requested number of timesteps, then wait for the output-layer classification
// and report it through done/result/err.
//
// Handshake: a source beat transfers on a clock edge where src_valid and
// src_ready are both high; src_ready is high for every cycle of RUN and low in
// every other state, and net_step marks exactly the cycles that transfer.
module inference_sequencer
   import snn_pkg::*;
#(
   parameter int STEP_WIDTH   = DEF_STEP_WIDTH,
   parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
   parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [STEP_WIDTH-1:0]   num_steps,
   input  logic                    abort,
   input  logic                    src_valid,
   output logic                    src_ready,
   output logic                    net_clear,
   output logic                    net_valid,
   output logic                    net_step,
   input  logic [OUTPUT_WIDTH-1:0] ol_result,
   input  logic                    ol_valid,
   output logic                    busy,
   output logic                    done,
   output logic [OUTPUT_WIDTH-1:0] result,
   output logic                    err
);

   localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   seq_state_t                state, state_n;
   logic [STEP_WIDTH-1:0]     steps_q, steps_n;
   logic [STEP_WIDTH-1:0]     step_cnt, step_cnt_n, step_inc;
   logic [CW-1:0]             clr_cnt, clr_cnt_n;
   logic [TW-1:0]             tmo_cnt, tmo_cnt_n;
   logic [OUTPUT_WIDTH-1:0]   result_n;
   logic                      err_n;
   logic                      abort_hit;

   // src_ready is registered, so the accepted-beat strobe is the only combinational output.
   assign net_step = src_valid & src_ready;
   assign step_inc = step_cnt + STEP_WIDTH'(1);

   // Next-state and next-value logic; abort overrides every other transition.
   always_comb begin
      state_n    = state;
      steps_n    = steps_q;
      step_cnt_n = step_cnt;
      clr_cnt_n  = clr_cnt;
      tmo_cnt_n  = tmo_cnt;
      result_n   = result;
      err_n      = err;
      abort_hit  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               result_n = '0;
               if (num_steps == '0) begin
                  // Nothing to run: report an error without touching the network.
                  err_n   = 1'b1;
                  state_n = S_DONE;
               end else begin
                  err_n      = 1'b0;
                  steps_n    = num_steps;
                  step_cnt_n = '0;
                  clr_cnt_n  = '0;
                  state_n    = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
               state_n = S_RUN;
            end else begin
               clr_cnt_n = clr_cnt + CW'(1);
            end
         end
         S_RUN: begin
            if (net_step) begin
               step_cnt_n = step_inc;
               if (step_inc == steps_q) begin
                  tmo_cnt_n = '0;
                  state_n   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (ol_valid) begin
               result_n = ol_result;
               err_n    = 1'b0;
               state_n  = S_DONE;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               err_n   = 1'b1;
               state_n = S_DONE;
            end else begin
               tmo_cnt_n = tmo_cnt + TW'(1);
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
      if (abort && is_busy(state)) begin
         state_n   = S_IDLE;
         result_n  = result;
         err_n     = err;
         abort_hit = 1'b1;
      end
   end

   // State, counters and all registered outputs; outputs are decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         steps_q   <= '0;
         step_cnt  <= '0;
         clr_cnt   <= '0;
         tmo_cnt   <= '0;
         result    <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         net_valid <= 1'b0;
         src_ready <= 1'b0;
         net_clear <= 1'b1;
      end else begin
         state     <= state_n;
         steps_q   <= steps_n;
         step_cnt  <= step_cnt_n;
         clr_cnt   <= clr_cnt_n;
         tmo_cnt   <= tmo_cnt_n;
         result    <= result_n;
         err       <= err_n;
         busy      <= is_busy(state_n);
         done      <= (state_n == S_DONE);
         net_valid <= (state_n == S_RUN);
         src_ready <= (state_n == S_RUN);
         net_clear <= (state_n == S_CLEAR) || abort_hit;
      end
   end

endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter STEP_WIDTH, default 8, width of the timestep count.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 4, width of the class index.
REQ-003 SHALL have parameter CLEAR_CYCLES, default 2, cycles net_clear is held per inference.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum cycles to wait for ol_valid.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1: request one inference; sampled only in IDLE.
REQ-008 SHALL have port num_steps, input, STEP_WIDTH: timestep count, captured with start.
REQ-009 SHALL have port abort, input, 1: cancel the current inference.
REQ-010 SHALL have ports src_valid (input, 1) and src_ready (output, 1): input-sample handshake; a beat is accepted when both are high.
REQ-011 SHALL have port net_clear, output, 1: network and output-layer reset request, active-high.
REQ-012 SHALL have port net_valid, output, 1: drives the output layer in_valid.
REQ-013 SHALL have port net_step, output, 1: network advance enable, equal to src_valid & src_ready.
REQ-014 SHALL have ports ol_result (input, OUTPUT_WIDTH) and ol_valid (input, 1): output-layer result and its one-cycle strobe.
REQ-015 SHALL have ports busy (output, 1), done (output, 1), result (output, OUTPUT_WIDTH) and err (output, 1).

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, RUN, WAIT, DONE.
REQ-017 SHALL, in IDLE with start=1 and num_steps!=0, latch num_steps and enter CLEAR on the next cycle.
REQ-018 SHALL, in IDLE with start=1 and num_steps==0, enter DONE with err=1 and result=0, without touching the network.
REQ-019 SHALL hold net_clear=1 for exactly CLEAR_CYCLES cycles in CLEAR, then enter RUN.
REQ-020 SHALL, in RUN, hold net_valid=1 and src_ready=1 continuously, including cycles with src_valid=0, so that the output layer sees no premature falling edge.
REQ-021 SHALL count accepted beats with a STEP_WIDTH counter, and SHALL enter WAIT on the cycle after the beat that makes count==num_steps.
REQ-022 SHALL deassert net_valid and src_ready in WAIT, IDLE, CLEAR and DONE; no beat is accepted outside RUN.
REQ-023 SHALL, in WAIT, capture ol_result into result on the cycle ol_valid=1, then enter DONE with err=0.
REQ-024 SHALL, if ol_valid is not seen within TIMEOUT cycles of entering WAIT, enter DONE with err=1 and result unchanged.
REQ-025 SHALL ignore ol_valid pulses that arrive outside WAIT.
REQ-026 SHALL assert done for exactly one cycle in DONE, then return to IDLE; result and err hold until the next start is accepted.
REQ-027 SHALL assert busy in CLEAR, RUN and WAIT, and deassert it in IDLE and DONE.
REQ-028 SHALL ignore start unless the FSM is in IDLE.
REQ-029 SHALL, on abort in CLEAR, RUN or WAIT, enter IDLE next cycle, pulse net_clear for one cycle, and not assert done; abort SHALL take priority over all other transitions in the same cycle.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, enter IDLE and clear the step counter and the timeout counter.
REQ-031 SHALL, on rst=1, set busy=0, done=0, err=0, result=0, net_valid=0, src_ready=0 and net_step=0.
REQ-032 SHALL assert net_clear=1 while rst=1, so that a reset mid-inference also clears the network.

Structure
REQ-033 SHALL place the state enum and the default parameter constants in a shared package, snn_pkg.
REQ-034 SHALL drive all outputs from registers, except net_step, which is combinational.
REQ-035 SHALL be a single module with no sub-modules.

Verification
REQ-036 SHALL cover: start with num_steps=4 and src_valid=1 continuously -> 2 net_clear cycles, then exactly 4 net_step pulses, then net_valid falls; ol_valid with ol_result=7 -> done=1 for one cycle, result=7, err=0.
REQ-037 SHALL cover: num_steps=3 with src_valid gapped 1,0,0,1,1 -> net_valid stays high across the gaps, exactly 3 net_step pulses, then WAIT.
REQ-038 SHALL cover: start with num_steps=0 -> done on the following cycle, err=1, result=0, net_clear never asserted.
REQ-039 SHALL cover: no ol_valid after the steps -> done after 15 WAIT cycles with err=1.
REQ-040 SHALL cover: abort after the 2nd step, and separately rst=1 during RUN -> IDLE, done=0, net_clear asserted, a following start runs normally.
REQ-041 SHALL cover: start pulsed while busy, and ol_valid pulsed while in RUN -> no state or result change.
